hello_world_detect: RTL and testbench



---
 rtl/hello_world_detect.sv | 118 +++++++++++
 tb/tb_hello_world_detect.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hello_world_detect.sv
// Recogniser for the 16-byte message "Hello, World! \n\r" arriving one byte per strobe.
// Optional mid-message idle timeout is enabled by defining HWD_TIMEOUT_EN.

module hello_world_mem (
  input  logic [3:0] i_addr,
  output logic [7:0] o_data
);
  always_comb begin
    o_data = 8'h00;
    case (i_addr)
      4'h0: o_data = 8'h48; // H
      4'h1: o_data = 8'h65; // e
      4'h2: o_data = 8'h6C; // l
      4'h3: o_data = 8'h6C; // l
      4'h4: o_data = 8'h6F; // o
      4'h5: o_data = 8'h2C; // ,
      4'h6: o_data = 8'h20; // space
      4'h7: o_data = 8'h57; // W
      4'h8: o_data = 8'h6F; // o
      4'h9: o_data = 8'h72; // r
      4'hA: o_data = 8'h6C; // l
      4'hB: o_data = 8'h64; // d
      4'hC: o_data = 8'h21; // !
      4'hD: o_data = 8'h20; // space
      4'hE: o_data = 8'h0A; // \n
      4'hF: o_data = 8'h0D; // \r
      default: o_data = 8'h00;
    endcase
  end
endmodule

module hello_world_detect #(
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  input  logic [7:0]    i_data,
  output logic [3:0]    o_index,
  output logic          o_match,
  output logic          o_err,
  output logic [CW-1:0] o_count
);
  localparam logic [7:0] CHAR_H = 8'h48;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("hello_world_detect: TIMEOUT must be at least 1");
  end

  logic [3:0]    index_q;
  logic          match_q;
  logic          err_q;
  logic [CW-1:0] count_q;
  logic [7:0]    expected;
  logic          timeout_hit;

  hello_world_mem u_mem (
    .i_addr (index_q),
    .o_data (expected)
  );

`ifdef HWD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q;

  // Expiry fires on the TIMEOUT-th idle cycle; a strobe in that cycle takes precedence.
  assign timeout_hit = !i_stb && (index_q != 4'd0) && (timer_q == TLAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      timer_q <= '0;
    end else if (i_stb || index_q == 4'd0 || timeout_hit) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      index_q <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      match_q <= 1'b0;
      err_q   <= 1'b0;
      if (i_stb) begin
        if (i_data == expected) begin
          if (index_q == 4'hF) begin
            index_q <= '0;
            match_q <= 1'b1;
            if (count_q != '1) count_q <= count_q + CW'(1);
          end else begin
            index_q <= index_q + 4'd1;
          end
        end else begin
          // A non-'H' byte at index 0 is line noise; 'H' only starts a message, so restart is exact.
          err_q   <= (index_q != 4'd0);
          index_q <= (i_data == CHAR_H) ? 4'd1 : 4'd0;
        end
      end else if (timeout_hit) begin
        index_q <= '0;
      end
    end
  end

  assign o_index = index_q;
  assign o_match = match_q;
  assign o_err   = err_q;
  assign o_count = count_q;
endmodule

// File: tb/tb_hello_world_detect.sv
// Directed bench for hello_world_detect: vector table plus multi-cycle sequences.
// Timeout sequences are exercised only when HWD_TIMEOUT_EN is defined.

module tb_hello_world_detect;
`ifdef HWD_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 1000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic [7:0]  data;
  logic [3:0]  idx, idx2;
  logic        match, match2, err, err2;
  logic [15:0] count;
  logic [1:0]  count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hello_world_detect #(.CW(16), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_data(data),
    .o_index(idx), .o_match(match), .o_err(err), .o_count(count)
  );

  hello_world_detect #(.CW(2), .TIMEOUT(TO)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_data(data),
    .o_index(idx2), .o_match(match2), .o_err(err2), .o_count(count2)
  );

  typedef struct {
    logic        stb;
    logic [7:0]  data;
    logic [3:0]  idx;
    logic        m;
    logic        e;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  logic [7:0] msg [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
                           8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20, 8'h0A, 8'h0D};
  int match_seen;
  int err_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic s, input logic [7:0] d, input logic [3:0] i,
                              input logic m, input logic e, input logic [15:0] c);
    vec_t v;
    v.stb = s; v.data = d; v.idx = i; v.m = m; v.e = e; v.cnt = c;
    vq.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1; stb = 1'b0; data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one byte for a single cycle and tally the resulting pulses.
  task automatic send(input logic [7:0] b);
    stb = 1'b1; data = b;
    @(posedge clk); #1;
    stb = 1'b0;
    if (match) match_seen++;
    if (err) err_seen++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (match) match_seen++;
      if (err) err_seen++;
    end
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; data = 8'h00;
    #12;
    chk("reset_index", idx, 4'd0);
    chk("reset_match", match, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_count", count, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      add(1'b1, msg[i], (i == 15) ? 4'd0 : 4'(i + 1), i == 15, 1'b0, (i == 15) ? 16'd1 : 16'd0);
    add(1'b0, 8'h48, 4'd0, 1'b0, 1'b0, 16'd1);
    add(1'b1, 8'h48, 4'd1, 1'b0, 1'b0, 16'd1);
    add(1'b1, 8'h65, 4'd2, 1'b0, 1'b0, 16'd1);
    add(1'b1, 8'h6C, 4'd3, 1'b0, 1'b0, 16'd1);
    add(1'b1, 8'h70, 4'd0, 1'b0, 1'b1, 16'd1);
    add(1'b1, 8'h48, 4'd1, 1'b0, 1'b0, 16'd1);
    add(1'b1, 8'h65, 4'd2, 1'b0, 1'b0, 16'd1);
    add(1'b1, 8'h48, 4'd1, 1'b0, 1'b1, 16'd1);
    for (int i = 1; i < 16; i++)
      add(1'b1, msg[i], (i == 15) ? 4'd0 : 4'(i + 1), i == 15, 1'b0, (i == 15) ? 16'd2 : 16'd1);
    add(1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 16'd2);
    add(1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 16'd2);
    for (int i = 0; i < 5; i++)
      add(1'b1, msg[i], 4'(i + 1), 1'b0, 1'b0, 16'd2);
    add(1'b1, 8'h58, 4'd0, 1'b0, 1'b1, 16'd2);
    add(1'b1, 8'h48, 4'd1, 1'b0, 1'b0, 16'd2);
    add(1'b0, 8'h65, 4'd1, 1'b0, 1'b0, 16'd2);
    add(1'b1, 8'h48, 4'd1, 1'b0, 1'b1, 16'd2);
    add(1'b1, 8'h65, 4'd2, 1'b0, 1'b0, 16'd2);

    foreach (vq[n]) begin
      stb = vq[n].stb; data = vq[n].data;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_index", n), idx, vq[n].idx);
      chk($sformatf("vec%0d_match", n), match, vq[n].m);
      chk($sformatf("vec%0d_err", n), err, vq[n].e);
      chk($sformatf("vec%0d_count", n), count, vq[n].cnt);
    end
    stb = 1'b0;

    // Three messages with 2-cycle gaps between strobes.
    do_reset();
    match_seen = 0; err_seen = 0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 16; i++) begin
        send(msg[i]);
        idle(2);
      end
    chk("gap_matches", match_seen, 3);
    chk("gap_errs", err_seen, 0);
    chk("gap_count", count, 16'd3);
    chk("gap_index", idx, 4'd0);

    // Asynchronous reset mid-message.
    for (int i = 0; i < 5; i++) send(msg[i]);
    chk("pre_reset_index", idx, 4'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_index", idx, 4'd0);
    chk("async_reset_count", count, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Narrow counter saturates at 3, back-to-back messages.
    begin
      logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int r = 0; r < 5; r++) begin
        for (int i = 0; i < 16; i++) send(msg[i]);
        chk($sformatf("sat_count_%0d", r), count2, exp2[r]);
      end
    end
    chk("wide_count_5", count, 16'd5);

`ifdef HWD_TIMEOUT_EN
    do_reset();
    match_seen = 0; err_seen = 0;
    send(8'h48); send(8'h65); send(8'h6C);
    idle(3);
    chk("to_before_expiry", idx, 4'd3);
    idle(1);
    chk("to_expired_index", idx, 4'd0);
    chk("to_no_err", err_seen, 0);
    send(8'h48); send(8'h65); send(8'h6C);
    idle(3);
    send(8'h6C);
    chk("to_stb_wins_index", idx, 4'd4);
    chk("to_stb_wins_err", err_seen, 0);
    idle(3);
    chk("to_timer_reloaded", idx, 4'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
